// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame sequencer driving start/data/parity/stop strobes and data_valid.
// Optional UART_RX_ERR_FLAGS_EN adds err_flags = {par_err, stp_err} captured at each frame end.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  deser_en,
  output logic                  data_valid
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic [1:0]            err_flags
`endif
);

  localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_new, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  par_on_q;
  logic                  latch_cfg, dv_d, at_strobe, at_last;
  logic                  err_load, err_clr;

  // Bit period is forced even and clamped so the majority window and strobe fit inside it.
  always_comb begin
    p_new = PRESCALE & ~PRESCALE_W'(1);
    if (p_new < P_MIN) p_new = P_MIN;
  end

  assign at_strobe   = (edge_cnt == (p_q >> 1) + PRESCALE_W'(2));
  assign at_last     = (edge_cnt == p_q - PRESCALE_W'(1));
  assign dat_samp_en = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    latch_cfg   = 1'b0;
    dv_d        = 1'b0;
    err_load    = 1'b0;
    err_clr     = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    deser_en    = 1'b0;
    edge_d      = (state_q == IDLE || at_last) ? '0 : edge_cnt + PRESCALE_W'(1);

    case (state_q)
      IDLE: begin
        if (!RX_IN) begin
          state_d   = START;
          latch_cfg = 1'b1;
        end
      end
      START: begin
        strt_chk_en = at_strobe;
        if (at_last) begin
          if (strt_glitch) begin
            state_d = IDLE;
            err_clr = 1'b1;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        deser_en = at_strobe;
        if (at_last) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_on_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        par_chk_en = at_strobe;
        if (at_last) state_d = STOP;
      end
      STOP: begin
        stp_chk_en = at_strobe;
        if (at_last) begin
          dv_d     = !stp_err && (!par_err || !par_on_q);
          err_load = 1'b1;
          // A low line here is the next start bit; re-latch config for that frame.
          if (!RX_IN) begin
            state_d   = START;
            latch_cfg = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_cnt   <= '0;
      bit_q      <= '0;
      p_q        <= '0;
      par_on_q   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt   <= edge_d;
      bit_q      <= bit_d;
      data_valid <= dv_d;
      if (latch_cfg) begin
        p_q      <= p_new;
        par_on_q <= PAR_EN;
      end
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_flags <= '0;
    end else if (err_clr) begin
      err_flags <= '0;
    end else if (err_load) begin
      err_flags <= {par_err & par_on_q, stp_err};
    end
  end
`else
  logic unused_err;
  assign unused_err = err_load ^ err_clr;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: driver pushes expected bytes/cycles, monitor checks data_valid and strobes.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] PRESCALE = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic       strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
  logic [1:0] err_flags;
`endif

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PRESCALE    (PRESCALE),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .deser_en    (deser_en),
    .data_valid  (data_valid)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .err_flags   (err_flags)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          cur_s = 6;
  logic        odd_mode = 1'b0;
  logic [7:0]  rx_shift = 8'h00;
  int          n_strt = 0, n_deser = 0, n_par = 0, n_stp = 0, n_dv = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Neighbouring checker/deserializer models: sample on strobe, result valid next cycle.
  initial begin : checkers
    logic g, pe, se, g_en, p_en, s_en;
    forever begin
      @(negedge CLK);
      g_en = strt_chk_en;
      p_en = par_chk_en;
      s_en = stp_chk_en;
      g    = RX_IN;
      pe   = (^rx_shift) ^ RX_IN ^ odd_mode;
      se   = ~RX_IN;
      if (deser_en) rx_shift = {RX_IN, rx_shift[7:1]};
      @(posedge CLK);
      #1;
      if (g_en) strt_glitch = g;
      if (p_en) par_err = pe;
      if (s_en) stp_err = se;
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (strt_chk_en | par_chk_en | stp_chk_en | deser_en) begin
        check("strobe_onehot", $countones({strt_chk_en, par_chk_en, stp_chk_en, deser_en}), 1);
        check("strobe_edge", edge_cnt, cur_s);
        if (strt_chk_en) n_strt++;
        if (deser_en) n_deser++;
        if (par_chk_en) n_par++;
        if (stp_chk_en) n_stp++;
      end
      if (data_valid) begin
        n_dv++;
        check("dv_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("dv_byte", rx_shift, e.data);
          check("dv_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit 2000000 ns expired");
    $fatal(1);
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Called and returns at posedge+1; mid-frame PRESCALE/PAR_EN are scrambled to prove they are latched.
  task automatic send_frame(input logic [7:0] data, input logic [5:0] pre, input logic pen,
                            input logic odd, input logic flip_par, input logic bad_stop,
                            input logic expect_dv, input int cut);
    int          p, nb, n;
    logic [10:0] bits;
    exp_t        e;
    p  = int'(pre & 6'h3e);
    if (p < 8) p = 8;
    nb = pen ? 11 : 10;
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (pen) begin
      bits[9]  = (^data) ^ odd ^ flip_par;
      bits[10] = ~bad_stop;
    end else begin
      bits[9]  = ~bad_stop;
      bits[10] = 1'b1;
    end
    PRESCALE = pre;
    PAR_EN   = pen;
    odd_mode = odd;
    cur_s    = p / 2 + 2;
    if (expect_dv) begin
      e.data = data;
      e.cyc  = cyc + 32'(p * nb) + 1;
      exp_q.push_back(e);
    end
    n = 0;
    for (int i = 0; i < nb; i++) begin
      RX_IN = bits[i];
      if (i == 1) begin
        PRESCALE = 6'd50;
        PAR_EN   = ~pen;
      end
      for (int c = 0; c < p; c++) begin
        if (n == cut) return;
        @(posedge CLK);
        #1;
        n++;
      end
    end
    RX_IN = 1'b1;
  endtask

  initial begin : main
    int b_strt, b_deser, b_par, b_stp, b_dv;
    #12;
    check("reset_outputs", {dat_samp_en, edge_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}, 0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(5);

    // P=8, no parity, 0xA5
    b_deser = n_deser; b_dv = n_dv;
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check("t1_deser_count", n_deser - b_deser, 8);
    check("t1_dv_count", n_dv - b_dv, 1);
    check("t1_drain", exp_q.size(), 0);

    // P=16, even parity, correct
    b_par = n_par; b_stp = n_stp; b_dv = n_dv;
    send_frame(8'h3C, 6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(30);
    check("t2_par_count", n_par - b_par, 1);
    check("t2_stp_count", n_stp - b_stp, 1);
    check("t2_dv_count", n_dv - b_dv, 1);

    // P=16, odd parity, wrong parity bit
    b_par = n_par; b_dv = n_dv;
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
    idle(30);
    check("t3_par_count", n_par - b_par, 1);
    check("t3_par_err", par_err, 1);
    check("t3_no_dv", n_dv - b_dv, 0);
    check("t3_idle", dat_samp_en, 0);
`ifdef UART_RX_ERR_FLAGS_EN
    check("t3_err_flags", err_flags, 2);
`endif

    // 3-cycle glitch, P=32
    b_strt = n_strt; b_deser = n_deser;
    PRESCALE = 6'd32;
    cur_s    = 18;
    RX_IN    = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    idle(60);
    check("t4_strt_count", n_strt - b_strt, 1);
    check("t4_no_deser", n_deser - b_deser, 0);
    check("t4_idle", dat_samp_en, 0);
`ifdef UART_RX_ERR_FLAGS_EN
    check("t4_err_cleared", err_flags, 0);
`endif

    // Back-to-back 0x00, 0xFF at P=8
    b_dv = n_dv; b_deser = n_deser;
    send_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check("t5_dv_count", n_dv - b_dv, 2);
    check("t5_deser_count", n_deser - b_deser, 16);
    check("t5_drain", exp_q.size(), 0);

    // Reset during DATA bit 4, then a clean frame
    send_frame(8'h5A, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 43);
    RST = 1'b0;
    #1;
    check("t6_reset_outputs", {dat_samp_en, edge_cnt, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid}, 0);
    RX_IN = 1'b1;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b1;
    b_strt = n_strt; b_deser = n_deser; b_par = n_par; b_stp = n_stp; b_dv = n_dv;
    idle(20);
    check("t6_no_strobes", (n_strt - b_strt) + (n_deser - b_deser) + (n_par - b_par) + (n_stp - b_stp), 0);
    check("t6_no_dv", n_dv - b_dv, 0);
    send_frame(8'h96, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check("t6_dv_count", n_dv - b_dv, 1);

    // PRESCALE=7 clamps to P=8, even parity
    b_dv = n_dv; b_par = n_par;
    send_frame(8'h81, 6'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    idle(20);
    check("t7_dv_count", n_dv - b_dv, 1);
    check("t7_par_count", n_par - b_par, 1);

    // P=10 clean frame back-to-back with a bad-stop frame
    b_dv = n_dv;
    send_frame(8'hC3, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h11, 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    idle(30);
    check("t8_dv_count", n_dv - b_dv, 1);
    check("t8_stp_err", stp_err, 1);
    check("t8_idle", dat_samp_en, 0);
    check("t8_drain", exp_q.size(), 0);
`ifdef UART_RX_ERR_FLAGS_EN
    check("t8_err_flags", err_flags, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
